// File: rtl/bus_arbiter.sv
// Two-master (CPU / video) arbiter for a single shared memory port.
// Video has priority, but the CPU is guaranteed a slot after STARVE_MAX back-to-back video grants.
module bus_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int STARVE_MAX  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        vga_req,
  input  logic [15:0] vga_addr,
  output logic [15:0] vga_rdata,
  output logic        vga_ack,
  output logic [15:0] ADDRBUS,
  output logic [1:0]  CTRLBUS,
  output logic [15:0] WDATABUS,
  input  logic [15:0] RDATABUS,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [3:0] WS   = 4'(WAIT_STATES);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] waitCnt;
  logic [3:0] starveCnt;
  logic       grantVga;
  logic       latWe;
  logic       vgaWins;

  // Video wins any contest unless the CPU has already been passed over STARVE_MAX times.
  assign vgaWins = vga_req && (!cpu_req || (starveCnt != SMAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      waitCnt   <= '0;
      starveCnt <= '0;
      grantVga  <= 1'b0;
      latWe     <= 1'b0;
      ADDRBUS   <= '0;
      CTRLBUS   <= 2'b00;
      WDATABUS  <= '0;
      cpu_rdata <= '0;
      vga_rdata <= '0;
      cpu_ack   <= 1'b0;
      vga_ack   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || vga_req) begin
            state    <= ACCESS;
            busy     <= 1'b1;
            waitCnt  <= WS;
            grantVga <= vgaWins;
            if (vgaWins) begin
              ADDRBUS <= vga_addr;
              CTRLBUS <= 2'b01;
              latWe   <= 1'b0;
              if (!cpu_req)
                starveCnt <= '0;
              else if (starveCnt != SMAX)
                starveCnt <= starveCnt + 4'd1;
            end else begin
              ADDRBUS   <= cpu_addr;
              CTRLBUS   <= cpu_we ? 2'b10 : 2'b01;
              latWe     <= cpu_we;
              starveCnt <= '0;
              if (cpu_we)
                WDATABUS <= cpu_wdata;
            end
          end
        end
        ACCESS: begin
          if (waitCnt == 4'd0) begin
            state   <= ACK;
            CTRLBUS <= 2'b00;
            if (grantVga)
              vga_ack <= 1'b1;
            else
              cpu_ack <= 1'b1;
            // Memory data is only valid in the final access cycle, so capture on this edge.
            if (!latWe) begin
              if (grantVga)
                vga_rdata <= RDATABUS;
              else
                cpu_rdata <= RDATABUS;
            end
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        ACK: begin
          state   <= IDLE;
          cpu_ack <= 1'b0;
          vga_ack <= 1'b0;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

  localparam int WS   = 1;
  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, vga_req = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, vga_addr = '0, RDATABUS = '0;
  logic [15:0] cpu_rdata, vga_rdata, ADDRBUS, WDATABUS;
  logic        cpu_ack, vga_ack, busy;
  logic [1:0]  CTRLBUS;

  logic        z_vga_req = 1'b0;
  logic [15:0] z_vga_addr = '0, z_RDATABUS = '0;
  logic [15:0] z_cpu_rdata, z_vga_rdata, z_ADDRBUS, z_WDATABUS;
  logic        z_cpu_ack, z_vga_ack, z_busy;
  logic [1:0]  z_CTRLBUS;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.WAIT_STATES(WS), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_ack(vga_ack),
    .ADDRBUS(ADDRBUS), .CTRLBUS(CTRLBUS), .WDATABUS(WDATABUS), .RDATABUS(RDATABUS),
    .busy(busy)
  );

  bus_arbiter #(.WAIT_STATES(0), .STARVE_MAX(SMAX)) zdut (
    .clk(clk), .reset(reset),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(16'h0), .cpu_wdata(16'h0),
    .cpu_rdata(z_cpu_rdata), .cpu_ack(z_cpu_ack),
    .vga_req(z_vga_req), .vga_addr(z_vga_addr), .vga_rdata(z_vga_rdata), .vga_ack(z_vga_ack),
    .ADDRBUS(z_ADDRBUS), .CTRLBUS(z_CTRLBUS), .WDATABUS(z_WDATABUS), .RDATABUS(z_RDATABUS),
    .busy(z_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observes one transaction from the next sampling edge until an ack appears, presenting
  // rdValue on RDATABUS only in the final access cycle. ackWho: 0 none, 1 cpu, 2 vga, 3 both.
  task automatic collectTxn(input logic [15:0] rdValue, input bit scramble,
                            output int nAccess, output logic [1:0] ctrlSeen,
                            output logic [15:0] addrSeen, output logic [15:0] wdataSeen,
                            output int ackWho, output int ackAt, output bit bad);
    nAccess = 0; ctrlSeen = 2'b00; addrSeen = '0; wdataSeen = '0;
    ackWho = 0; ackAt = 0; bad = 1'b0;
    RDATABUS = ~rdValue;
    for (int c = 1; c <= 40 && ackWho == 0; c++) begin
      tick();
      if (CTRLBUS == 2'b11) bad = 1'b1;
      if (CTRLBUS != 2'b00) begin
        if (nAccess == 0) begin
          ctrlSeen = CTRLBUS; addrSeen = ADDRBUS; wdataSeen = WDATABUS;
        end else if (CTRLBUS !== ctrlSeen || ADDRBUS !== addrSeen ||
                     (ctrlSeen == 2'b10 && WDATABUS !== wdataSeen)) begin
          bad = 1'b1;
        end
        if (busy !== 1'b1) bad = 1'b1;
        nAccess++;
        RDATABUS = (nAccess == WS + 1) ? rdValue : ~rdValue;
      end
      if (cpu_ack === 1'b1 && vga_ack === 1'b1) ackWho = 3;
      else if (cpu_ack === 1'b1) ackWho = 1;
      else if (vga_ack === 1'b1) ackWho = 2;
      if (ackWho != 0) ackAt = c;
      if (scramble && c == 1) begin
        cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom); cpu_we = ~cpu_we;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    tests++; if (CTRLBUS !== 2'b00) begin failed++; $display("[TB] FAIL reset_ctrl got %b want 00", CTRLBUS); end
    tests++; if (ADDRBUS !== 16'h0 || WDATABUS !== 16'h0) begin failed++; $display("[TB] FAIL reset_buses got %h/%h want 0/0", ADDRBUS, WDATABUS); end
    tests++; if (cpu_ack !== 1'b0 || vga_ack !== 1'b0 || busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_flags got ack %b%b busy %b want 000", cpu_ack, vga_ack, busy); end
    tests++; if (cpu_rdata !== 16'h0 || vga_rdata !== 16'h0) begin failed++; $display("[TB] FAIL reset_rdata got %h/%h want 0/0", cpu_rdata, vga_rdata); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    int n, who, at; logic [1:0] ctl; logic [15:0] ad, wd; bit bad;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    collectTxn(16'hBEEF, 1'b0, n, ctl, ad, wd, who, at, bad);
    cpu_req = 1'b0;
    tests++; if (who != 1 || at != WS + 2) begin failed++; $display("[TB] FAIL cpu_read_ack got who=%0d at=%0d want 1 at %0d", who, at, WS + 2); end
    tests++; if (n != WS + 1 || ctl !== 2'b01 || ad !== 16'h1234 || bad) begin failed++; $display("[TB] FAIL cpu_read_bus got n=%0d ctl=%b addr=%h bad=%0d want %0d 01 1234 0", n, ctl, ad, bad, WS + 1); end
    tests++; if (cpu_rdata !== 16'hBEEF) begin failed++; $display("[TB] FAIL cpu_read_data got %h want beef", cpu_rdata); end
    tick();
    tests++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin failed++; $display("[TB] FAIL cpu_read_pulse got ack=%b busy=%b want 0 0", cpu_ack, busy); end
  endtask

  task automatic test_cpu_write();
    int n, who, at; logic [1:0] ctl; logic [15:0] ad, wd; bit bad;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hA5A5;
    collectTxn(16'h0F0F, 1'b1, n, ctl, ad, wd, who, at, bad);
    cpu_req = 1'b0;
    tests++; if (who != 1 || at != WS + 2) begin failed++; $display("[TB] FAIL cpu_write_ack got who=%0d at=%0d want 1 at %0d", who, at, WS + 2); end
    tests++; if (n != WS + 1 || ctl !== 2'b10 || ad !== 16'h0010 || wd !== 16'hA5A5 || bad) begin failed++; $display("[TB] FAIL cpu_write_bus got n=%0d ctl=%b addr=%h wd=%h bad=%0d", n, ctl, ad, wd, bad); end
    tests++; if (cpu_rdata !== 16'hBEEF) begin failed++; $display("[TB] FAIL cpu_write_rdata got %h want beef", cpu_rdata); end
    tick();
  endtask

  task automatic test_simultaneous();
    int n, who, at; logic [1:0] ctl; logic [15:0] ad, wd; bit bad;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    vga_req = 1'b1; vga_addr = 16'h4000;
    collectTxn(16'h1111, 1'b0, n, ctl, ad, wd, who, at, bad);
    vga_req = 1'b0;
    tests++; if (who != 2 || ad !== 16'h4000 || vga_rdata !== 16'h1111) begin failed++; $display("[TB] FAIL simul_first got who=%0d addr=%h vrd=%h want 2 4000 1111", who, ad, vga_rdata); end
    tick();
    collectTxn(16'h2222, 1'b0, n, ctl, ad, wd, who, at, bad);
    cpu_req = 1'b0;
    tests++; if (who != 1 || ad !== 16'h0100 || cpu_rdata !== 16'h2222 || bad) begin failed++; $display("[TB] FAIL simul_second got who=%0d addr=%h crd=%h bad=%0d want 1 0100 2222 0", who, ad, cpu_rdata, bad); end
    tick();
  endtask

  task automatic test_starvation();
    int n, who, at; logic [1:0] ctl; logic [15:0] ad, wd; bit bad;
    int expWho[8];
    expWho = '{2, 2, 2, 1, 2, 2, 2, 1};
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0C00;
    vga_req = 1'b1; vga_addr = 16'h0A00;
    for (int i = 0; i < 8; i++) begin
      collectTxn(16'(i), 1'b0, n, ctl, ad, wd, who, at, bad);
      tests++; if (who != expWho[i] || at != WS + 2 || bad) begin failed++; $display("[TB] FAIL starve_grant%0d got who=%0d at=%0d bad=%0d want %0d", i, who, at, bad, expWho[i]); end
      tick();
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_midflight();
    int n, who, at; logic [1:0] ctl; logic [15:0] ad, wd; bit bad;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2222;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    tests++; if (CTRLBUS !== 2'b00 || busy !== 1'b0 || cpu_ack !== 1'b0) begin failed++; $display("[TB] FAIL midreset_async got ctrl=%b busy=%b ack=%b want 00 0 0", CTRLBUS, busy, cpu_ack); end
    tests++; if (cpu_rdata !== 16'h0 || ADDRBUS !== 16'h0) begin failed++; $display("[TB] FAIL midreset_regs got rd=%h addr=%h want 0 0", cpu_rdata, ADDRBUS); end
    #3 reset = 1'b1;
    collectTxn(16'h3333, 1'b0, n, ctl, ad, wd, who, at, bad);
    cpu_req = 1'b0;
    tests++; if (who != 1 || at != WS + 2 || ad !== 16'h2222 || cpu_rdata !== 16'h3333) begin failed++; $display("[TB] FAIL midreset_retry got who=%0d at=%0d addr=%h rd=%h want 1 %0d 2222 3333", who, at, ad, cpu_rdata, WS + 2); end
    tick();
  endtask

  task automatic test_random_traffic();
    int n, who, at; logic [1:0] ctl; logic [15:0] ad, wd; bit bad;
    bit cpuPend = 0, vgaPend = 0, vgaWins;
    int starve = 0, expWho;
    logic [15:0] mCpuRd, mVgaRd, rd, expAddr;
    logic [1:0] expCtl;
    mCpuRd = cpu_rdata; mVgaRd = vga_rdata;
    for (int i = 0; i < 40; i++) begin
      if (!cpuPend && $urandom_range(1, 0) == 1) begin
        cpuPend = 1; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
      end
      if (!vgaPend && (!cpuPend || $urandom_range(1, 0) == 1)) begin
        vgaPend = 1; vga_addr = 16'($urandom);
      end
      cpu_req = cpuPend; vga_req = vgaPend;
      vgaWins = vgaPend && !(cpuPend && starve == SMAX);
      if (vgaWins) begin
        expWho = 2; expAddr = vga_addr; expCtl = 2'b01;
        starve = cpuPend ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
      end else begin
        expWho = 1; expAddr = cpu_addr; expCtl = cpu_we ? 2'b10 : 2'b01;
        starve = 0;
      end
      rd = 16'($urandom);
      if (expWho == 2) mVgaRd = rd;
      else if (expCtl == 2'b01) mCpuRd = rd;
      collectTxn(rd, 1'b0, n, ctl, ad, wd, who, at, bad);
      tests++; if (who != expWho || at != WS + 2 || n != WS + 1 || bad) begin failed++; $display("[TB] FAIL rand%0d_grant got who=%0d at=%0d n=%0d bad=%0d want %0d %0d %0d", i, who, at, n, bad, expWho, WS + 2, WS + 1); end
      tests++; if (ctl !== expCtl || ad !== expAddr || (expCtl == 2'b10 && wd !== cpu_wdata)) begin failed++; $display("[TB] FAIL rand%0d_bus got ctl=%b addr=%h wd=%h want %b %h", i, ctl, ad, wd, expCtl, expAddr); end
      tests++; if (cpu_rdata !== mCpuRd || vga_rdata !== mVgaRd) begin failed++; $display("[TB] FAIL rand%0d_rdata got %h/%h want %h/%h", i, cpu_rdata, vga_rdata, mCpuRd, mVgaRd); end
      if (expWho == 2) begin vgaPend = 0; vga_req = 1'b0; end
      else begin cpuPend = 0; cpu_req = 1'b0; end
      tick();
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_zero_wait();
    int nAcc = 0, ackAt = 0;
    logic [15:0] addrSeen = '0;
    z_vga_req = 1'b1; z_vga_addr = 16'h8000; z_RDATABUS = 16'h0000;
    for (int c = 1; c <= 20 && ackAt == 0; c++) begin
      tick();
      if (z_CTRLBUS == 2'b01) begin
        nAcc++; addrSeen = z_ADDRBUS; z_RDATABUS = 16'h7777;
      end else begin
        z_RDATABUS = 16'h0000;
      end
      if (z_vga_ack === 1'b1) begin ackAt = c; z_vga_req = 1'b0; end
    end
    tests++; if (nAcc != 1 || ackAt != 2 || addrSeen !== 16'h8000) begin failed++; $display("[TB] FAIL zero_wait_timing got n=%0d ackAt=%0d addr=%h want 1 2 8000", nAcc, ackAt, addrSeen); end
    tests++; if (z_vga_rdata !== 16'h7777 || z_cpu_ack !== 1'b0) begin failed++; $display("[TB] FAIL zero_wait_data got rd=%h cack=%b want 7777 0", z_vga_rdata, z_cpu_ack); end
    tick();
    tests++; if (z_vga_ack !== 1'b0 || z_busy !== 1'b0) begin failed++; $display("[TB] FAIL zero_wait_pulse got ack=%b busy=%b want 0 0", z_vga_ack, z_busy); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_simultaneous();
    test_starvation();
    test_reset_midflight();
    test_random_traffic();
    test_zero_wait();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 1: extra memory cycles per access; legal range 0..15.
REQ-002 Parameter STARVE_MAX, default 3: maximum consecutive VGA grants while CPU waits; legal range 1..15.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU access request; held high until cpu_ack is sampled.
REQ-007 cpu_we  in  1  1 = write, 0 = read.
REQ-008 cpu_addr  in  16  CPU address.
REQ-009 cpu_wdata  in  16  CPU write data.
REQ-010 cpu_rdata  out  16  CPU read data.
REQ-011 cpu_ack  out  1  one-cycle completion pulse to the CPU.
REQ-012 vga_req  in  1  video fetch request (read only); held high until vga_ack is sampled.
REQ-013 vga_addr  in  16  video fetch address.
REQ-014 vga_rdata  out  16  video read data.
REQ-015 vga_ack  out  1  one-cycle completion pulse to the video fetcher.
REQ-016 ADDRBUS  out  16  memory address.
REQ-017 CTRLBUS  out  2  00 none, 01 read, 10 write; 11 SHALL never be driven.
REQ-018 WDATABUS  out  16  memory write data.
REQ-019 RDATABUS  in  16  memory read data, valid in the last ACCESS cycle.
REQ-020 busy  out  1  high whenever state is not IDLE.

Function
REQ-021 FSM states: IDLE, ACCESS, ACK; all outputs registered.
REQ-022 IDLE: if any req is high at the edge, select a winner, latch its address/we/wdata, load wait counter with WAIT_STATES, and go to ACCESS; otherwise stay.
REQ-023 Arbitration: VGA wins when both request, unless starve_cnt == STARVE_MAX, in which case the CPU wins.
REQ-024 starve_cnt: increments (saturating at STARVE_MAX) on a VGA grant with cpu_req high; clears on any CPU grant or on a VGA grant with cpu_req low.
REQ-025 ACCESS: drive latched ADDRBUS; CTRLBUS = 01 for read, 10 for write; WDATABUS = latched wdata on write. Counter decrements each cycle; when counter == 0, go to ACK.
REQ-026 On a read, the winner's rdata register SHALL capture RDATABUS at the ACCESS->ACK edge.
REQ-027 ACK: CTRLBUS = 00; winner's ack high for exactly one cycle; next state IDLE.
REQ-028 Occupancy: ACCESS lasts WAIT_STATES+1 cycles; ack is high in cycle WAIT_STATES+2 after the sampling edge; back-to-back throughput is one transaction per WAIT_STATES+3 cycles.
REQ-029 Input changes during ACCESS/ACK are ignored (latched values used).
REQ-030 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-031 rdata registers hold until the next read completion for the same requester; CPU writes leave cpu_rdata unchanged.
REQ-032 cpu_ack and vga_ack SHALL never be high simultaneously.
REQ-033 In IDLE, ADDRBUS and WDATABUS hold their last values and CTRLBUS = 00.

Reset
REQ-034 reset low SHALL immediately force: state IDLE, CTRLBUS 00, ADDRBUS 0, WDATABUS 0, cpu_ack 0, vga_ack 0, cpu_rdata 0, vga_rdata 0, starve_cnt 0, busy 0.
REQ-035 An in-flight transaction SHALL be aborted by reset with no ack; after reset release, requests are re-arbitrated from IDLE.

Verification
REQ-036 CPU read with WAIT_STATES=1: cpu_addr 0x1234, RDATABUS 0xBEEF -> ADDRBUS 0x1234 and CTRLBUS 01 for 2 cycles; cpu_ack high for 1 cycle; cpu_rdata 0xBEEF.
REQ-037 CPU write: addr 0x0010, wdata 0xA5A5 -> CTRLBUS 10 and WDATABUS 0xA5A5 for 2 cycles; cpu_ack pulses once; cpu_rdata unchanged.
REQ-038 cpu_req and vga_req raised on the same edge -> VGA transaction completes first (vga_ack), then CPU (cpu_ack); acks never overlap.
REQ-039 Both reqs held continuously, STARVE_MAX=3 -> grant order V,V,V,C,V,V,V,C.
REQ-040 reset asserted in the 2nd ACCESS cycle -> CTRLBUS 00 and busy 0 without waiting for a clock; no ack; after release, the still-held req completes normally.
REQ-041 WAIT_STATES=0, VGA read 0x8000 -> one ACCESS cycle; vga_ack in 2nd cycle after the sampling edge; vga_rdata updated.
